// File: rtl/aes_pkg.sv
// aes_pkg: shared AES widths, byte addressing, scheduler state and grant encodings
package aes_pkg;
    localparam int AES_STATE_W = 128;
    localparam int AES_WORD_W  = 32;
    localparam int AES_BYTES   = 16;
    typedef enum logic [1:0] {IDLE, BUSY_ST, BUSY_KW} state_t;
    typedef enum logic {GRANT_ST, GRANT_KW} grant_t;
    // byte i occupies bits 8i..8i+7 of an ascending-range vector
    function automatic int unsigned byte_lsb(input int unsigned i);
        return 8 * i;
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box lookup
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    localparam logic [0:2047] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign out_o = TABLE[{in_i, 3'b000} +: 8];
endmodule

// File: rtl/subbytes_sched.sv
// subbytes_sched: iterative SubBytes/SubWord engine sharing LANES S-boxes between cipher and key schedule
module subbytes_sched
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   st_valid,
    output logic                   st_ready,
    input  logic [0:AES_STATE_W-1] st_in,
    output logic [0:AES_STATE_W-1] st_out,
    output logic                   st_done,
    input  logic                   kw_valid,
    output logic                   kw_ready,
    input  logic [0:AES_WORD_W-1]  kw_in,
    output logic [0:AES_WORD_W-1]  kw_out,
    output logic                   kw_done,
    output logic                   busy
);
    localparam int ST_N = AES_BYTES / LANES;
    localparam int KW_N = (LANES >= 4) ? 1 : 4 / LANES;

    state_t                  state_q, state_d;
    grant_t                  last_q, last_d, grant;
    logic [3:0]              cnt_q, cnt_d;
    logic [0:AES_STATE_W-1]  work_q, work_d, res_q, res_d, st_out_q, st_out_d;
    logic [0:AES_WORD_W-1]   kw_out_q, kw_out_d;
    logic                    st_done_q, st_done_d, kw_done_q, kw_done_d, last_chunk;
    logic [3:0]              lane_idx [LANES];
    logic [7:0]              lane_in [LANES];
    logic [7:0]              lane_out [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_idx[g] = 4'(int'(cnt_q) * LANES + g);
        assign lane_in[g]  = work_q[byte_lsb(lane_idx[g]) +: 8];
        aes_sbox u_sbox (.in_i(lane_in[g]), .out_o(lane_out[g]));
    end

    // on contention, favour whoever was not served last
    assign grant = (st_valid && kw_valid) ? (last_q == GRANT_ST ? GRANT_KW : GRANT_ST)
                                          : (kw_valid ? GRANT_KW : GRANT_ST);
    assign st_ready   = !rst && state_q == IDLE && grant == GRANT_ST;
    assign kw_ready   = !rst && state_q == IDLE && grant == GRANT_KW;
    assign last_chunk = cnt_q == 4'((state_q == BUSY_ST ? ST_N : KW_N) - 1);
    assign busy       = state_q != IDLE;
    assign st_out     = st_out_q;
    assign kw_out     = kw_out_q;
    assign st_done    = st_done_q;
    assign kw_done    = kw_done_q;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        res_d     = res_q;
        st_out_d  = st_out_q;
        kw_out_d  = kw_out_q;
        st_done_d = 1'b0;
        kw_done_d = 1'b0;
        if (state_q != IDLE) begin
            for (int k = 0; k < LANES; k++) res_d[byte_lsb(lane_idx[k]) +: 8] = lane_out[k];
            cnt_d = cnt_q + 4'd1;
        end
        if (st_ready && st_valid) begin
            work_d  = st_in;
            cnt_d   = '0;
            last_d  = GRANT_ST;
            state_d = BUSY_ST;
        end else if (kw_ready && kw_valid) begin
            work_d  = {kw_in, {(AES_STATE_W - AES_WORD_W){1'b0}}};
            cnt_d   = '0;
            last_d  = GRANT_KW;
            state_d = BUSY_KW;
        end
        if (last_chunk && state_q == BUSY_ST) begin
            st_out_d  = res_d;
            st_done_d = 1'b1;
            state_d   = IDLE;
        end else if (last_chunk && state_q == BUSY_KW) begin
            kw_out_d  = res_d[0:AES_WORD_W-1];
            kw_done_d = 1'b1;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= GRANT_KW;
            cnt_q     <= '0;
            work_q    <= '0;
            res_q     <= '0;
            st_out_q  <= '0;
            kw_out_q  <= '0;
            st_done_q <= 1'b0;
            kw_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            res_q     <= res_d;
            st_out_q  <= st_out_d;
            kw_out_q  <= kw_out_d;
            st_done_q <= st_done_d;
            kw_done_q <= kw_done_d;
        end
    end
endmodule

// File: doc/subbytes_sched.md
Name: subbytes_sched

Overview:
- Iterative SubBytes engine that time-shares LANES byte S-box lanes between two requesters:
  - the cipher round datapath, which needs a full 128-bit SubBytes;
  - the key-expansion unit, which needs a 32-bit SubWord.
- Replaces 20 parallel S-boxes with LANES S-boxes.
- Processes LANES bytes per cycle under a valid/ready handshake, with round-robin arbitration between the two requesters.
- Sits between the round controller/key schedule and the existing 8-bit combinational SBOX.

Parameters:
- LANES, 4, number of SBOX instances. Legal values are 1, 2, 4, 8 and 16 (must divide 16).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- st_valid  in  1  state request valid.
- st_ready  out  1  state request accepted when st_valid and st_ready are both high.
- st_in  in  [0:127]  state bytes; byte i occupies bits 8i..8i+7 (byte 0 at bit 0).
- st_out  out  [0:127]  SubBytes result, same byte ordering as st_in.
- st_done  out  1  one-cycle pulse marking st_out valid.
- kw_valid  in  1  key word request valid.
- kw_ready  out  1  key word request accept.
- kw_in  in  [0:31]  word bytes; byte j occupies bits 8j..8j+7.
- kw_out  out  [0:31]  SubWord result.
- kw_done  out  1  one-cycle pulse marking kw_out valid.
- busy  out  1  high while a job is in progress (BUSY_ST or BUSY_KW).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, ports clk and rst.
- Reset values:
  - FSM goes to IDLE, chunk counter to 0, last_grant to KW.
  - st_out=0, kw_out=0, st_done=0, kw_done=0, busy=0.
  - st_ready and kw_ready are forced to 0 while rst is high.
- FSM has three states: IDLE, BUSY_ST, BUSY_KW.
- Arbitration (combinational, IDLE only):
  - Only st_valid high: grant ST. Only kw_valid high: grant KW.
  - Both high: grant the requester that was NOT last_grant.
  - st_ready = IDLE and grant==ST; kw_ready = IDLE and grant==KW.
  - Both readies are 0 in the BUSY states.
  - A ready may depend on the other requester's valid. Requesters must not make their valid depend on ready.
- Accept edge:
  - Input is captured into a work register, counter cleared, last_grant updated.
  - FSM moves to BUSY_ST or BUSY_KW.
  - Inputs may change freely after the accept edge.
- Busy cycles:
  - Each cycle the lanes substitute work bytes [cnt*LANES, cnt*LANES+LANES-1] into the result register, then cnt increments.
  - BUSY_ST runs 16/LANES cycles.
  - BUSY_KW runs max(1, 4/LANES) cycles. For LANES>4, only lanes 0..3 are used for KW; the remaining lanes are don't-care.
- Completion:
  - On the edge that writes the last chunk: the result register is copied to st_out/kw_out, the matching done pulse is high for the following cycle, and the FSM returns to IDLE.
  - The next request may be accepted in that same done cycle (back-to-back).
- Latency from accept edge to done edge: ST = 16/LANES cycles; KW = max(1, 4/LANES) cycles.
- Output hold: st_out and kw_out hold their values until the next completion of the same requester; the other requester never disturbs them.
- Simultaneous events:
  - Both valid in IDLE: round-robin as above.
  - Valid arriving while busy waits; it is never dropped.
- Reset mid-operation: the job is aborted, no done pulse is produced, and outputs go to their reset values.
- S-box sharing: lane k input mux selects the work byte at index cnt*LANES+k.

Decomposition:
- Shared package aes_pkg holds:
  - AES_STATE_W=128, AES_WORD_W=32, AES_BYTES=16;
  - the byte-index helper (byte i ↔ bits 8i..8i+7);
  - the FSM state encoding;
  - the grant encoding (ST/KW).
- Sub-module: reuse the existing combinational SBOX, instantiated LANES times in a generate loop. No new sub-module is needed.

Test Plan:
- Reset release → ready behaviour:
  - After reset deassert, with st_valid=1 and kw_valid=0, st_ready=1.
  - st_in=00112233445566778899aabbccddeeff → st_done 4 cycles after accept (LANES=4), st_out=638293c31bfc33f5c4eeacea4bc12816.
- SubWord:
  - kw_in=cf4f3c09 → kw_done 1 cycle after accept, kw_out=8a84eb01.
  - st_out is unchanged.
- Contention:
  - st_valid and kw_valid both high from reset → ST granted first.
  - KW is accepted in ST's done cycle.
  - The next simultaneous pair grants ST again (alternation verified over 4 jobs).
- Hold and input isolation:
  - Change st_in on the cycle after accept → result still matches the captured value.
  - st_out holds until the next ST completion.
- Reset mid-job:
  - Assert rst 2 cycles into BUSY_ST → no st_done.
  - Outputs read 0; busy=0 within the same cycle (asynchronous).
- Parameter sweep with LANES=1 and LANES=16:
  - ST latency 16 and 1 cycles respectively.
  - KW latency 4 and 1 cycles respectively.
  - Same vectors give identical results.
